// File: rtl/uniter_sched_pkg.sv
// Shared types and default sizing for the uniter round-robin scheduler.
package uniter_sched_pkg;

   typedef enum logic {ST_IDLE, ST_BUSY} sched_state_t;

   localparam int unsigned DEF_PORTS_N   = 2;
   localparam int unsigned DEF_MAX_BEATS = 8;

endpackage

// File: rtl/uniter_rr_sched_prio_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, modulo PORTS_W.
module rr_prio_pick
   import uniter_sched_pkg::*;
#(
   parameter int unsigned PORTS_N = DEF_PORTS_N,
   parameter int unsigned PORTS_W = 1 << PORTS_N
) (
   input  logic [PORTS_W-1:0] i_req,
   input  logic [PORTS_N-1:0] i_ptr,
   output logic               o_any,
   output logic [PORTS_N-1:0] o_idx
);

   logic [PORTS_W-1:0] w_rot;
   logic [PORTS_N-1:0] w_off;

   // Rotate so i_ptr lands at bit 0; the PORTS_N-bit index sum wraps modulo PORTS_W.
   always_comb begin
      w_rot = '0;
      for (int unsigned i = 0; i < PORTS_W; i++) begin
         w_rot[i] = i_req[PORTS_N'(i) + i_ptr];
      end
   end

   always_comb begin
      o_any = 1'b0;
      w_off = '0;
      for (int unsigned i = 0; i < PORTS_W; i++) begin
         if (w_rot[i] && !o_any) begin
            o_any = 1'b1;
            w_off = PORTS_N'(i);
         end
      end
   end

   assign o_idx = w_off + i_ptr;

endmodule

// File: rtl/uniter_rr_sched.sv
// Round-robin scheduler driving the uniter select; holds a grant per packet, rotates on release.
module uniter_rr_sched
   import uniter_sched_pkg::*;
#(
   parameter int unsigned PORTS_N   = DEF_PORTS_N,
   parameter int unsigned PORTS_W   = 1 << PORTS_N,
   parameter int unsigned MAX_BEATS = DEF_MAX_BEATS,
   parameter int unsigned BEAT_W    = $clog2(MAX_BEATS + 1)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [PORTS_W-1:0] i_req,
   input  logic [PORTS_W-1:0] i_last,
   input  logic               i_slave_ready,
   output logic [PORTS_N-1:0] o_sel,
   output logic [PORTS_W-1:0] o_gnt,
   output logic               o_busy,
   output logic [BEAT_W-1:0]  o_beat_cnt
);

   sched_state_t       r_state, w_state_nxt;
   logic [PORTS_N-1:0] r_ptr, w_ptr_nxt;
   logic [PORTS_N-1:0] r_sel, w_sel_nxt;
   logic [PORTS_W-1:0] r_gnt, w_gnt_nxt;
   logic [BEAT_W-1:0]  r_beat, w_beat_nxt;

   logic               w_busy;
   logic               w_fire;
   logic               w_release;
   logic [PORTS_N-1:0] w_sel_inc;
   logic [PORTS_N-1:0] w_pick_ptr;
   logic               w_pick_any;
   logic [PORTS_N-1:0] w_pick_idx;
   logic [PORTS_W-1:0] w_pick_onehot;

   assign w_busy        = (r_state == ST_BUSY);
   assign w_fire        = w_busy & i_req[r_sel] & i_slave_ready;
   assign w_release     = w_fire & (i_last[r_sel] | (r_beat == BEAT_W'(MAX_BEATS - 1)));
   assign w_sel_inc     = r_sel + PORTS_N'(1);
   // One picker serves both cases: idle arbitration from r_ptr, release arbitration past r_sel.
   assign w_pick_ptr    = w_busy ? w_sel_inc : r_ptr;
   assign w_pick_onehot = PORTS_W'(1) << w_pick_idx;

   rr_prio_pick #(
      .PORTS_N (PORTS_N),
      .PORTS_W (PORTS_W)
   ) u_pick (
      .i_req (i_req),
      .i_ptr (w_pick_ptr),
      .o_any (w_pick_any),
      .o_idx (w_pick_idx)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_sel_nxt   = r_sel;
      w_gnt_nxt   = r_gnt;
      w_beat_nxt  = r_beat;
      unique case (r_state)
         ST_IDLE: begin
            if (w_pick_any) begin
               w_state_nxt = ST_BUSY;
               w_sel_nxt   = w_pick_idx;
               w_gnt_nxt   = w_pick_onehot;
               w_beat_nxt  = '0;
            end
         end
         ST_BUSY: begin
            if (w_release) begin
               w_ptr_nxt  = w_sel_inc;
               w_beat_nxt = '0;
               if (w_pick_any) begin
                  w_sel_nxt = w_pick_idx;
                  w_gnt_nxt = w_pick_onehot;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_gnt_nxt   = '0;
               end
            end else if (w_fire) begin
               w_beat_nxt = r_beat + BEAT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
            w_beat_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_sel   <= '0;
         r_gnt   <= '0;
         r_beat  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_sel   <= w_sel_nxt;
         r_gnt   <= w_gnt_nxt;
         r_beat  <= w_beat_nxt;
      end
   end

   assign o_sel      = r_sel;
   assign o_gnt      = r_gnt;
   assign o_busy     = w_busy;
   assign o_beat_cnt = r_beat;

endmodule

// File: tb/tb_uniter_rr_sched.sv
// Directed bench for uniter_rr_sched with PORTS_N=2, MAX_BEATS=4.
module tb_uniter_rr_sched;

   localparam int unsigned PN = 2;
   localparam int unsigned PW = 4;
   localparam int unsigned MB = 4;
   localparam int unsigned BW = 3;

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic [PW-1:0] i_req;
   logic [PW-1:0] i_last;
   logic          i_slave_ready;
   logic [PN-1:0] o_sel;
   logic [PW-1:0] o_gnt;
   logic          o_busy;
   logic [BW-1:0] o_beat_cnt;

   int n_checks = 0;
   int n_errors = 0;

   uniter_rr_sched #(
      .PORTS_N   (PN),
      .MAX_BEATS (MB)
   ) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_req         (i_req),
      .i_last        (i_last),
      .i_slave_ready (i_slave_ready),
      .o_sel         (o_sel),
      .o_gnt         (o_gnt),
      .o_busy        (o_busy),
      .o_beat_cnt    (o_beat_cnt)
   );

   always #5 i_clk = ~i_clk;

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [PN-1:0] sel, input logic [PW-1:0] gnt,
                          input logic busy, input logic [BW-1:0] beat);
      chk({tag, ".sel"},  32'(o_sel),      32'(sel));
      chk({tag, ".gnt"},  32'(o_gnt),      32'(gnt));
      chk({tag, ".busy"}, 32'(o_busy),     32'(busy));
      chk({tag, ".beat"}, 32'(o_beat_cnt), 32'(beat));
   endtask

   initial begin
      // 1: reset with all requests pending
      i_reset = 1'b1; i_req = 4'b1111; i_last = 4'b0000; i_slave_ready = 1'b1;
      #1;
      cyc(); cyc();
      chk_all("t1_reset", 2'd0, 4'b0000, 1'b0, 3'd0);
      i_reset = 1'b0;
      cyc();
      chk_all("t1_first", 2'd0, 4'b0001, 1'b1, 3'd0);

      // 2: single-beat packets rotate with no bubble
      i_last = 4'b1111;
      cyc(); chk_all("t2_s1", 2'd1, 4'b0010, 1'b1, 3'd0);
      cyc(); chk_all("t2_s2", 2'd2, 4'b0100, 1'b1, 3'd0);
      cyc(); chk_all("t2_s3", 2'd3, 4'b1000, 1'b1, 3'd0);
      cyc(); chk_all("t2_s0", 2'd0, 4'b0001, 1'b1, 3'd0);

      // 3: port0 ends its packet on the third fire
      i_req = 4'b0011; i_last = 4'b0000;
      cyc(); chk_all("t3_b1", 2'd0, 4'b0001, 1'b1, 3'd1);
      cyc(); chk_all("t3_b2", 2'd0, 4'b0001, 1'b1, 3'd2);
      i_last = 4'b0001;
      cyc(); chk_all("t3_rot", 2'd1, 4'b0010, 1'b1, 3'd0);

      // 4: move grant to port2, then force release at MAX_BEATS and re-grant the same port
      i_req = 4'b0110; i_last = 4'b0010;
      cyc(); chk_all("t4_g2", 2'd2, 4'b0100, 1'b1, 3'd0);
      i_req = 4'b0100; i_last = 4'b0000;
      cyc(); chk_all("t4_b1", 2'd2, 4'b0100, 1'b1, 3'd1);
      cyc(); chk_all("t4_b2", 2'd2, 4'b0100, 1'b1, 3'd2);
      cyc(); chk_all("t4_b3", 2'd2, 4'b0100, 1'b1, 3'd3);
      cyc(); chk_all("t4_regrant", 2'd2, 4'b0100, 1'b1, 3'd0);

      // 5: backpressure holds everything
      cyc(); cyc();
      chk_all("t5_pre", 2'd2, 4'b0100, 1'b1, 3'd2);
      i_slave_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc(); chk_all("t5_hold", 2'd2, 4'b0100, 1'b1, 3'd2);
      end
      i_slave_ready = 1'b1;
      cyc(); chk_all("t5_resume", 2'd2, 4'b0100, 1'b1, 3'd3);

      // 6: async reset mid-burst, then arbitration restarts from ptr=0
      cyc(); chk_all("t6_regrant", 2'd2, 4'b0100, 1'b1, 3'd0);
      cyc(); cyc();
      chk_all("t6_mid", 2'd2, 4'b0100, 1'b1, 3'd2);
      #3 i_reset = 1'b1;
      #1 chk_all("t6_async", 2'd0, 4'b0000, 1'b0, 3'd0);
      i_req = 4'b0000;
      cyc(); chk_all("t6_held", 2'd0, 4'b0000, 1'b0, 3'd0);
      i_reset = 1'b0;
      cyc(); chk_all("t6_idle", 2'd0, 4'b0000, 1'b0, 3'd0);
      i_req = 4'b1100;
      cyc(); chk_all("t6_ptr0", 2'd2, 4'b0100, 1'b1, 3'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
